icache_bank_dispatch: RTL
=========================

# icache_bank_dispatch

Request dispatcher sitting directly upstream of the 16-way request demux in the TP32-to-ICache (4 KB, wired-OR) interconnect.
- Accepts one instruction-fetch request at a time from the core over a valid/ready handshake.
- Drives the demux select and the single-bit request strobe that the demux fans out to one of 16 cache banks.
- Waits for the wired-OR bank acknowledge and returns the wired-OR read data, or an error on timeout.

## Interface
Parameters:
- ADDR_W, 32, core fetch address width
- DATA_W, 32, fetch data width
- TIMEOUT, 15, max cycles in REQ before an error response; legal range 1..255

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core fetch request valid
- req_ready  out  1  dispatcher can accept a request
- req_addr  in  ADDR_W  byte address of the fetch
- bank_sel  out  4  select into the demux; equals addr[5:2], word-interleaved banks
- bank_req  out  1  request strobe into the demux input
- bank_idx  out  6  word index within the bank; equals addr[11:6]
- bank_ack  in  1  wired-OR acknowledge from all banks
- bank_rdata  in  DATA_W  wired-OR read data, valid in the cycle bank_ack=1
- resp_valid  out  1  response to core valid
- resp_ready  in  1  core accepts response
- resp_data  out  DATA_W  captured fetch data
- resp_err  out  1  response is a timeout error (resp_data=0)

## Operation
- FSM with three states: IDLE, REQ, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid: capture addr[5:2] into bank_sel and addr[11:6] into bank_idx, clear the timer, go to REQ.
  - addr[1:0] and addr[ADDR_W-1:12] are ignored.
- **REQ**
  - bank_req=1 and req_ready=0.
  - bank_sel and bank_idx are held constant.
  - Timer increments every cycle.
  - On bank_ack=1: capture bank_rdata into resp_data, set resp_err=0, go to RESP.
  - Else when timer==TIMEOUT-1: set resp_data=0 and resp_err=1, go to RESP.
  - If ack and timeout coincide, ack wins.
- **RESP**
  - resp_valid=1 and bank_req=0.
  - resp_data and resp_err are held until resp_ready=1, then go to IDLE.
- bank_ack seen in IDLE or RESP (a stale/late ack) is ignored. It is never captured.
- bank_sel is never X or Z. The demux decodes with exact-match compare, so an unknown select silently drops the strobe.
- bank_sel and bank_idx keep their last value in IDLE and RESP. Only bank_req qualifies them.

## Timing
- Reset values (asynchronous on rst_n low):
  - state=IDLE, req_ready=1
  - bank_sel=0, bank_idx=0, bank_req=0, timer=0
  - resp_valid=0, resp_data=0, resp_err=0
- Request acceptance is a cycle where req_valid && req_ready. bank_req rises on the next edge.
- Minimum latency is 2 cycles from acceptance to resp_valid: 1 cycle in REQ with ack, then registered into RESP.
- Throughput is at most one request per 3 cycles.
  - req_ready returns to 1 the cycle after the resp_valid && resp_ready handshake.
  - There is no IDLE bypass.
- bank_req is a registered level. It deasserts on the same edge that enters RESP. Banks see exactly one contiguous strobe per transaction.
- Timeout: with no ack, resp_valid with resp_err=1 asserts TIMEOUT+1 cycles after acceptance.
- Reset asserted mid-REQ drops bank_req asynchronously and discards the transaction. No response is issued.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package icache_ic_pkg holds:
  - the state enum (IDLE, REQ, RESP)
  - constant BANK_SEL_LSB=2, BANK_SEL_W=4, BANK_IDX_LSB=6, BANK_IDX_W=6
- A timer sub-module is natural: icache_req_timer (clear, enable, terminal-count output).
- Everything else lives in one module.

## Test plan
- Reset then addr=0x0000_0A44, ack on first REQ cycle with rdata=0xDEAD_BEEF:
  - bank_sel=1, bank_idx=0x29, bank_req high exactly 1 cycle
  - resp_valid 2 cycles after acceptance with resp_data=0xDEAD_BEEF, resp_err=0
- Sweep addr[5:2] over 0..15, ack after 3 cycles:
  - bank_sel matches each value
  - bank_req high 3 cycles per request
  - every response correct
- No ack, TIMEOUT=15:
  - resp_valid at cycle 16 after acceptance with resp_err=1, resp_data=0
  - bank_req low from that edge
- Backpressure: resp_ready low for 5 cycles:
  - resp_valid, resp_data and resp_err held stable, req_ready=0
  - a late bank_ack pulse with rdata=0x1234 during RESP leaves resp_data unchanged
- Ack and timeout on the same cycle (ack at cycle 15):
  - resp_err=0 and data captured
- rst_n pulsed low mid-REQ (asynchronous, between edges):
  - bank_req and resp_valid go 0 immediately
  - after release, req_ready=1 and bank_sel=0
  - no response is ever issued for the dropped request

Source files
------------

// File: rtl/icache_ic_pkg.sv
// rtl/icache_ic_pkg.sv - shared state encoding and address field positions for the icache bank dispatcher
package icache_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BANK_SEL_LSB = 2;
  localparam int BANK_SEL_W   = 4;
  localparam int BANK_IDX_LSB = 6;
  localparam int BANK_IDX_W   = 6;

endpackage

// File: rtl/icache_req_timer.sv
// rtl/icache_req_timer.sv - request timeout counter with clear, enable and terminal-count flag
module icache_req_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/icache_bank_dispatch.sv
// rtl/icache_bank_dispatch.sv - single-outstanding fetch dispatcher driving the 16-way bank demux
module icache_bank_dispatch
  import icache_ic_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic [BANK_SEL_W-1:0] bank_sel,
  output logic                  bank_req,
  output logic [BANK_IDX_W-1:0] bank_idx,
  input  logic                  bank_ack,
  input  logic [DATA_W-1:0]     bank_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_err
);

  state_t state_q;
  state_t state_d;
  logic   timeout_tc;
  logic   unused_addr_bits;

  // Byte offset and bits above the 4 KB window play no part in bank routing.
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_W-1:12]};

  icache_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == IDLE),
    .enable (state_q == REQ),
    .tc     (timeout_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = REQ;
      REQ:     if (bank_ack || timeout_tc) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      bank_req   <= 1'b0;
      resp_valid <= 1'b0;
      bank_sel   <= '0;
      bank_idx   <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      req_ready  <= (state_d == IDLE);
      bank_req   <= (state_d == REQ);
      resp_valid <= (state_d == RESP);
      if (state_q == IDLE && req_valid) begin
        bank_sel <= req_addr[BANK_SEL_LSB +: BANK_SEL_W];
        bank_idx <= req_addr[BANK_IDX_LSB +: BANK_IDX_W];
      end
      if (state_q == REQ) begin
        if (bank_ack) begin
          resp_data <= bank_rdata;
          resp_err  <= 1'b0;
        end else if (timeout_tc) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
    end
  end

endmodule
